// File: rtl/sync_timing_generator_pkg.sv
// Shared timing constants for the 640x480@60 display mode and the period-length helper.
package sync_timing_generator_pkg;

    function automatic int calc_total(input int active, input int front_porch,
                                      input int sync_width, input int back_porch);
        return active + front_porch + sync_width + back_porch;
    endfunction

    localparam int H_ACTIVE      = 640;
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_WIDTH  = 96;
    localparam int H_BACK_PORCH  = 48;
    localparam int H_TOTAL       = calc_total(H_ACTIVE, H_FRONT_PORCH, H_SYNC_WIDTH, H_BACK_PORCH);

    localparam int V_ACTIVE      = 480;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_WIDTH  = 2;
    localparam int V_BACK_PORCH  = 33;
    localparam int V_TOTAL       = calc_total(V_ACTIVE, V_FRONT_PORCH, V_SYNC_WIDTH, V_BACK_PORCH);

endpackage

// File: rtl/sync_timing_generator_wrap_counter.sv
// Position counter 0..TOTAL-1 with enable, restart (dominant) and a registered wrap pulse.
// The combinational next value is exported so the owner can register decodes in lockstep.
module wrap_counter #(
    parameter int COUNTER_WIDTH = 11,
    parameter int TOTAL         = 800
) (
    input  logic                     control_clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     restart,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic [COUNTER_WIDTH-1:0] count_next,
    output logic                     wrap_pulse
);

    localparam logic [COUNTER_WIDTH-1:0] TERMINAL = COUNTER_WIDTH'(TOTAL - 1);
    localparam logic [COUNTER_WIDTH-1:0] ONE      = COUNTER_WIDTH'(1);

    logic at_terminal;

    assign at_terminal = (count == TERMINAL);

    always_comb begin
        count_next = count;
        if (restart) begin
            count_next = '0;
        end else if (enable) begin
            count_next = at_terminal ? '0 : count + ONE;
        end
    end

    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            count      <= count_next;
            wrap_pulse <= enable && !restart && at_terminal;
        end
    end

endmodule

// File: rtl/sync_timing_generator.sv
// One axis of a display timing generator: position counter plus registered active/sync decode.
// Horizontal and vertical axes cascade by feeding horizontal period_end into vertical enable.
module sync_timing_generator
    import sync_timing_generator_pkg::*;
#(
    parameter int ACTIVE           = H_ACTIVE,
    parameter int FRONT_PORCH      = H_FRONT_PORCH,
    parameter int SYNC_WIDTH       = H_SYNC_WIDTH,
    parameter int BACK_PORCH       = H_BACK_PORCH,
    parameter int COUNTER_WIDTH    = 11,
    parameter int SYNC_ACTIVE_HIGH = 0
) (
    input  logic                     control_clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     restart,
    output logic [COUNTER_WIDTH-1:0] counter_out,
    output logic                     sync,
    output logic                     active,
    output logic                     period_end
);

    localparam int   TOTAL      = calc_total(ACTIVE, FRONT_PORCH, SYNC_WIDTH, BACK_PORCH);
    localparam int   SYNC_START = ACTIVE + FRONT_PORCH;
    localparam int   SYNC_END   = SYNC_START + SYNC_WIDTH;
    localparam logic SYNC_IDLE  = (SYNC_ACTIVE_HIGH == 0);

    if (TOTAL == 0 || (64'd1 << COUNTER_WIDTH) < 64'(TOTAL)) begin : g_bad_params
        $error("sync_timing_generator: TOTAL=%0d is zero or does not fit in %0d bits",
               TOTAL, COUNTER_WIDTH);
    end

    logic [COUNTER_WIDTH-1:0] next_count;

    wrap_counter #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .TOTAL         (TOTAL)
    ) u_counter (
        .control_clock (control_clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .restart       (restart),
        .count         (counter_out),
        .count_next    (next_count),
        .wrap_pulse    (period_end)
    );

    function automatic logic decode_active(input logic [COUNTER_WIDTH-1:0] pos);
        return 32'(pos) < ACTIVE;
    endfunction

    // Empty sync window (SYNC_WIDTH=0) never matches, so sync stays at its idle level.
    function automatic logic decode_sync(input logic [COUNTER_WIDTH-1:0] pos);
        logic in_window;
        in_window = (32'(pos) >= SYNC_START) && (32'(pos) < SYNC_END);
        return SYNC_IDLE ? !in_window : in_window;
    endfunction

    // Decoding the next count keeps active/sync aligned with counter_out in every cycle.
    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            active <= (ACTIVE > 0);
            sync   <= SYNC_IDLE;
        end else begin
            active <= decode_active(next_count);
            sync   <= decode_sync(next_count);
        end
    end

endmodule
